// File: rtl/booth_mult_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_mult_pipe_param                                        |
// | Description : Pipelined radix-4 Modified Booth multiplier with valid/ready |
// |               handshake, per-transaction signed/unsigned selection and a   |
// |               global-stall pipeline of 1..3 register stages.               |
// |               Optional macro BOOTH_MAC_EN turns out_prod into an           |
// |               accumulator (out_prod += product, cleared by in_acc_clr).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module booth_mult_pipe_param #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic                 in_acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_zero
);

  localparam int c_pw = 2 * WIDTH;      // product width
  localparam int c_ew = WIDTH + 2;      // extended multiplier width
  localparam int c_ng = WIDTH / 2 + 1;  // Booth groups
  localparam int c_nr = c_ng + 1;       // partial-product rows plus the +1 correction row

  // Global stall: every stage moves together whenever the output slot can move.
  logic w_adv;
  logic w_accept;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid & w_adv;

  // Stage-1 logic: operand extension, Booth recoding and partial products.
  logic [c_pw-1:0]            w_a_ext;
  logic [c_ew:0]              w_b_pad;
  logic                       w_zero_in;
  logic [c_nr-1:0][c_pw-1:0]  w_pp;

  // Build one shifted row per Booth digit; negatives use ~x here and a +1 in the last row.
  always_comb begin
    w_a_ext   = {{(c_pw-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
    w_b_pad   = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
    w_zero_in = (in_a == '0) | (in_b == '0);
    w_pp      = '0;
    for (int i = 0; i < c_ng; i++) begin
      logic [2:0]      v_trip;
      logic            v_neg;
      logic            v_one;
      logic            v_two;
      logic [c_pw-1:0] v_mag;
      v_trip = w_b_pad[2*i +: 3];
      v_neg  = v_trip[2] & ~(v_trip[1] & v_trip[0]);
      v_one  = v_trip[1] ^ v_trip[0];
      v_two  = (v_trip == 3'b011) | (v_trip == 3'b100);
      v_mag  = v_one ? w_a_ext : (v_two ? (w_a_ext << 1) : '0);
      w_pp[i] = (v_neg ? ~v_mag : v_mag) << (2 * i);
      w_pp[c_nr-1][2*i] = v_neg;
    end
    // A zero operand keeps every row quiet and yields a zero product.
    if (w_zero_in) begin
      w_pp = '0;
    end
  end

  // Signals entering the reduction stage (registered or straight through).
  logic [c_nr-1:0][c_pw-1:0]  w_s2_pp;
  logic                       w_s2_valid;
  logic                       w_s2_zero;
  logic                       w_s2_clr;

  if (STAGES >= 2) begin : g_s1_reg
    logic [c_nr-1:0][c_pw-1:0] r_pp;
    logic                      r_valid;
    logic                      r_zero;
    logic                      r_clr;

    // Stage-1 valid bit shifts on every advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_accept;
      end
    end

    // Stage-1 data loads only for a real transaction.
    always_ff @(posedge clk) begin
      if (w_adv & w_accept) begin
        r_pp   <= w_pp;
        r_zero <= w_zero_in;
        r_clr  <= in_acc_clr;
      end
    end

    assign w_s2_pp    = r_pp;
    assign w_s2_valid = r_valid;
    assign w_s2_zero  = r_zero;
    assign w_s2_clr   = r_clr;
  end else begin : g_s1_bypass
    assign w_s2_pp    = w_pp;
    assign w_s2_valid = w_accept;
    assign w_s2_zero  = w_zero_in;
    assign w_s2_clr   = in_acc_clr;
  end

  // Carry-save reduction of all rows to one sum/carry pair.
  logic [c_pw-1:0] w_csa_sum;
  logic [c_pw-1:0] w_csa_carry;

  // Each 3:2 compressor folds one more row into the running sum/carry pair.
  always_comb begin
    w_csa_sum   = w_s2_pp[0];
    w_csa_carry = w_s2_pp[1];
    for (int k = 2; k < c_nr; k++) begin
      logic [c_pw-1:0] v_x;
      logic [c_pw-1:0] v_t;
      v_x         = w_s2_pp[k];
      v_t         = w_csa_sum ^ w_csa_carry ^ v_x;
      w_csa_carry = ((w_csa_sum & w_csa_carry) | (w_csa_sum & v_x) | (w_csa_carry & v_x)) << 1;
      w_csa_sum   = v_t;
    end
  end

  // Signals entering the final adder stage.
  logic [c_pw-1:0] w_s3_sum;
  logic [c_pw-1:0] w_s3_carry;
  logic            w_s3_valid;
  logic            w_s3_zero;
  logic            w_s3_clr;

  if (STAGES >= 3) begin : g_s2_reg
    logic [c_pw-1:0] r_sum;
    logic [c_pw-1:0] r_carry;
    logic            r_valid;
    logic            r_zero;
    logic            r_clr;

    // Stage-2 valid bit shifts on every advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_s2_valid;
      end
    end

    // Stage-2 data loads only for a real transaction.
    always_ff @(posedge clk) begin
      if (w_adv & w_s2_valid) begin
        r_sum   <= w_csa_sum;
        r_carry <= w_csa_carry;
        r_zero  <= w_s2_zero;
        r_clr   <= w_s2_clr;
      end
    end

    assign w_s3_sum   = r_sum;
    assign w_s3_carry = r_carry;
    assign w_s3_valid = r_valid;
    assign w_s3_zero  = r_zero;
    assign w_s3_clr   = r_clr;
  end else begin : g_s2_bypass
    assign w_s3_sum   = w_csa_sum;
    assign w_s3_carry = w_csa_carry;
    assign w_s3_valid = w_s2_valid;
    assign w_s3_zero  = w_s2_zero;
    assign w_s3_clr   = w_s2_clr;
  end

  // Final carry-propagate add.
  logic [c_pw-1:0] w_prod;
  assign w_prod = w_s3_sum + w_s3_carry;

`ifndef BOOTH_MAC_EN
  // Accumulate-clear only matters for the accumulator build.
  logic w_unused_acc_clr;
  assign w_unused_acc_clr = w_s3_clr;
`endif

  // Output stage: bubbles drop out_valid but leave product and flag untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_zero  <= 1'b0;
    end else if (w_adv) begin
      out_valid <= w_s3_valid;
      if (w_s3_valid) begin
        out_zero <= w_s3_zero;
`ifdef BOOTH_MAC_EN
        out_prod <= w_prod + (w_s3_clr ? '0 : out_prod);
`else
        out_prod <= w_prod;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_booth_mult_pipe_param                                     |
// | Description : Self-checking bench for booth_mult_pipe_param: directed      |
// |               vectors, stall/reset scenarios and randomized traffic        |
// |               compared against an arithmetic reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_booth_mult_pipe_param;

  localparam int W      = 16;
  localparam int STAGES = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_signed;
  logic            in_acc_clr;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_prod;
  logic            out_zero;

  booth_mult_pipe_param #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_acc_clr (in_acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic           z;
    logic           clr;
  } exp_t;
  exp_t exp_q[$];

`ifdef BOOTH_MAC_EN
  logic [2*W-1:0] acc = '0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Plain-arithmetic reference: extend, multiply at 64 bits, keep the low 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic [63:0] x, y, p;
    x = s ? {{(64-W){a[W-1]}}, a} : {{(64-W){1'b0}}, a};
    y = s ? {{(64-W){b[W-1]}}, b} : {{(64-W){1'b0}}, b};
    p = x * y;
    return p[2*W-1:0];
  endfunction

  // Scoreboard: handshakes are observed on the falling edge, away from the active edge.
  initial begin
    exp_t           e;
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] held;
    bit             prev_stall;
    prev_stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_valid && in_ready)
          exp_q.push_back('{ref_mul(in_a, in_b, in_signed), (in_a == 0) || (in_b == 0), in_acc_clr});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            exp_p = e.p;
`ifdef BOOTH_MAC_EN
            acc   = e.clr ? e.p : acc + e.p;
            exp_p = acc;
`endif
            check("prod", out_prod, exp_p);
            check("zero_flag", out_zero, e.z);
            n_out++;
          end
        end
        if (out_valid && !out_ready) begin
          if (prev_stall) check("hold_prod", out_prod, held);
          held = out_prod;
          prev_stall = 1;
        end else begin
          prev_stall = 0;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  // Offer one operand pair and return just after the edge that accepted it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
    int n;
    in_a = a; in_b = b; in_signed = s; in_acc_clr = c; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("send_wait", in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Single op into an empty pipe: out_valid must rise exactly STAGES cycles later.
  task automatic lat_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp_val);
    in_a = a; in_b = b; in_signed = s; in_acc_clr = 1'b1; in_valid = 1'b1;
    check("lat_ready", in_ready, 1'b1);
    for (int i = 1; i <= STAGES; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
      if (i < STAGES) check("lat_early", out_valid, 1'b0);
    end
    check("lat_valid", out_valid, 1'b1);
    check("lat_prod", out_prod, exp_val);
    drain();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n0;
    int  n;
    bit  rnd_done;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_prod", out_prod, 32'h0);
    check("rst_zero", out_zero, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Signed -3 * 7.
    lat_op(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
    check("t1_zero", out_zero, 1'b0);

    // Corner operands.
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Back-to-back ops with a two-cycle output stall.
    n0 = n_out;
    fork
      begin
        send(16'd1, 16'd2, 1'b0, 1'b1);
        send(16'd3, 16'd4, 1'b0, 1'b1);
        send(16'd5, 16'd6, 1'b0, 1'b1);
        send(16'd7, 16'd8, 1'b0, 1'b1);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("t3_seen", out_valid, 1'b1);
        out_ready = 1'b0;
        #1 check("stall_ready0", in_ready, 1'b0);
        @(posedge clk); #2;
        check("stall_ready1", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("t3_count", n_out - n0, 4);

    // Zero operand, then a normal op.
    send(16'h0000, 16'h1234, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();
    check("t4_zero_flag", out_zero, 1'b1);
    lat_op(16'd2, 16'd3, 1'b0, 32'd6);
    check("t4_zero_clr", out_zero, 1'b0);

    // Reset with work in flight.
    in_a = 16'd11; in_b = 16'd13; in_signed = 1'b0; in_acc_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'd17; in_b = 16'd19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_valid", out_valid, 1'b0);
    check("t5_prod", out_prod, 32'h0);
    exp_q.delete();
`ifdef BOOTH_MAC_EN
    acc = '0;
`endif
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_stale", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    lat_op(16'd9, 16'd9, 1'b0, 32'd81);

`ifdef BOOTH_MAC_EN
    send(16'd3, 16'd4, 1'b0, 1'b1);
    send(16'd5, 16'd6, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    check("mac_acc", out_prod, 32'd42);
    lat_op(16'd1, 16'd1, 1'b0, 32'd1);
`endif

    // Randomized traffic with random gaps and random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
